// File: rtl/can_pkg.sv
// Shared CAN definitions: CRC-15 constants and the checker state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package can_pkg;

    localparam int CAN_CRC_W = 15;
    localparam logic [CAN_CRC_W-1:0] CAN_CRC15_POLY = 15'h4599;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        RXCRC = 2'd2,
        DONE  = 2'd3
    } crc_state_t;

endpackage

// File: rtl/can_crc_lfsr.sv
// One serial CRC step: shifts base left by one and folds in POLY when the din/MSB feedback is set.
// Latency: purely combinational, zero cycles.
// Backpressure: none, result always valid for the current inputs.
module can_crc_lfsr #(
    parameter int               CRC_W = 15,
    parameter logic [CRC_W-1:0] POLY  = 15'h4599
) (
    input  logic [CRC_W-1:0] base,
    input  logic             din,
    output logic [CRC_W-1:0] result
);

    logic nxt;

    // Feedback bit, then shift-and-conditionally-xor
    always_comb begin
        nxt    = din ^ base[CRC_W-1];
        result = {base[CRC_W-2:0], 1'b0} ^ (nxt ? POLY : '0);
    end

endmodule

// File: rtl/can_crc_chk.sv
// CAN frame CRC checker: accumulates the CRC over SOF..DATA, captures the received CRC field, compares.
// Latency: crc_ready/crc_err register on the edge that samples the last CRC bit, visible the next cycle.
// Backpressure: none; bits are consumed on the bit_valid strobe and the block never stalls the sender.
module can_crc_chk
    import can_pkg::*;
#(
    parameter int               CRC_W = CAN_CRC_W,
    parameter logic [CRC_W-1:0] POLY  = CAN_CRC15_POLY,
    parameter logic [CRC_W-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             din,
    input  logic             stuff_bit,
    input  logic             data_last,
    output logic [CRC_W-1:0] crc,
    output logic             crc_ready,
    output logic             crc_err,
    output logic             busy
);

    localparam int             CNT_W    = $clog2(CRC_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);

    crc_state_t       state, state_nxt;
    logic [CRC_W-1:0] rx_crc, rx_crc_nxt, crc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ready_nxt, err_nxt, busy_nxt;

    logic             accept;
    logic [CRC_W-1:0] step_base, step_res, rx_shift;

    // Stuff bits carry no payload, so they never count as a received bit
    assign accept    = bit_valid & ~stuff_bit;
    // The SOF bit is folded into INIT rather than the stale running CRC
    assign step_base = start ? INIT : crc;
    assign rx_shift  = {rx_crc[CRC_W-2:0], din};

    can_crc_lfsr #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_lfsr (
        .base   (step_base),
        .din    (din),
        .result (step_res)
    );

    // State register; rst wins over start and every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-datapath decode; start restarts the frame from any state
    always_comb begin
        state_nxt  = state;
        crc_nxt    = crc;
        rx_crc_nxt = rx_crc;
        cnt_nxt    = cnt;
        ready_nxt  = 1'b0;
        err_nxt    = crc_err;
        if (start) begin
            state_nxt  = CALC;
            crc_nxt    = accept ? step_res : INIT;
            rx_crc_nxt = '0;
            cnt_nxt    = '0;
            err_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                CALC: begin
                    if (accept) begin
                        crc_nxt = step_res;
                        if (data_last) begin
                            state_nxt = RXCRC;
                            cnt_nxt   = '0;
                        end
                    end
                end
                RXCRC: begin
                    if (accept) begin
                        rx_crc_nxt = rx_shift;
                        cnt_nxt    = cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state_nxt = DONE;
                            ready_nxt = 1'b1;
                            err_nxt   = (rx_shift != crc);
                        end
                    end
                end
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
        busy_nxt = (state_nxt == CALC) || (state_nxt == RXCRC);
    end

    // Datapath and output registers so every output comes straight from a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            crc       <= INIT;
            rx_crc    <= '0;
            cnt       <= '0;
            crc_ready <= 1'b0;
            crc_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            crc       <= crc_nxt;
            rx_crc    <= rx_crc_nxt;
            cnt       <= cnt_nxt;
            crc_ready <= ready_nxt;
            crc_err   <= err_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: doc/can_crc_chk.md
CAN_CRC_CHK -- requirements
Module: can_crc_chk

Interface
REQ-001 Parameter CRC_W, default 15: CRC register width in bits.
REQ-002 Parameter POLY, default 15'h4599: generator polynomial with implicit top term omitted, CRC_W bits.
REQ-003 Parameter INIT, default 0: CRC register value loaded on start, CRC_W bits.
REQ-004 clk  in  1  system clock, 100 MHz.
REQ-005 rst  in  1  reset; one clock, synchronous, active-high.
REQ-006 start  in  1  SOF marker; qualifies the SOF bit and restarts the block from any state.
REQ-007 bit_valid  in  1  one-cycle sample strobe for din.
REQ-008 din  in  1  received bit.
REQ-009 stuff_bit  in  1  the current sampled bit is a stuff bit and is excluded.
REQ-010 data_last  in  1  the current sampled bit is the last DATA-field bit.
REQ-011 crc  out  CRC_W  calculated CRC register.
REQ-012 crc_ready  out  1  one-cycle pulse: comparison complete.
REQ-013 crc_err  out  1  received CRC differs from calculated CRC.
REQ-014 busy  out  1  high in CALC and RXCRC.

Function
REQ-015 The block SHALL implement states IDLE, CALC, RXCRC and DONE.
REQ-016 The step function SHALL be: nxt = din XOR base[CRC_W-1]; result = {base[CRC_W-2:0],0} XOR (nxt ? POLY : 0).
REQ-017 An accepted bit SHALL be one with bit_valid=1 and stuff_bit=0; stuff_bit=1 SHALL make the bit and its data_last ignored.
REQ-018 start=1 in any state SHALL enter CALC and clear crc_err; if the SOF bit is accepted in that cycle, crc <= step(INIT, din), otherwise crc <= INIT.
REQ-019 In CALC, each accepted bit SHALL update crc <= step(crc, din), visible on the next cycle.
REQ-020 In CALC, an accepted bit with data_last=1 SHALL update crc, then enter RXCRC with the bit counter at 0.
REQ-021 In RXCRC, each accepted bit SHALL shift into rx_crc MSB first, increment the counter, and leave crc unchanged.
REQ-022 After the CRC_W-th accepted bit, the block SHALL enter DONE.
REQ-023 In DONE, the block SHALL pulse crc_ready for exactly one cycle, set crc_err = (rx_crc != crc), and return to IDLE on the next cycle.
REQ-024 crc_err SHALL hold its value until the next start or rst.
REQ-025 In IDLE, bit_valid, din and data_last SHALL be ignored; crc SHALL hold.
REQ-026 Latency: crc_ready SHALL assert on the cycle after the clock edge that samples the last CRC bit.
REQ-027 The counter width SHALL be $clog2(CRC_W+1); the counter SHALL never wrap.

Reset
REQ-028 rst SHALL set state=IDLE, crc=INIT, rx_crc=0, counter=0, crc_ready=0, crc_err=0 and busy=0 on the next clock edge.
REQ-029 rst SHALL take priority over start and over all other inputs, including mid-frame.

Structure
REQ-030 The shared package can_pkg SHALL hold CAN_CRC15_POLY (15'h4599), CAN_CRC_W (15) and the state enum.
REQ-031 The step function SHALL be a combinational sub-module, can_crc_lfsr, parametrised by CRC_W and POLY.
REQ-032 All outputs SHALL be driven directly from registers.

Verification
REQ-033 Frame: start with bit 0, then bit 1 with data_last -> crc=15'h4599; then feed 0x4599 MSB first -> crc_ready pulses once, crc_err=0.
REQ-034 Same frame, with stuff bit 1 inserted between the two data bits -> crc=15'h4599, crc_err=0.
REQ-035 Frame: bits 1, then 0 with data_last -> crc=15'h4EAB; feed 0x4EAA -> crc_ready pulses, crc_err=1, held until the next start.
REQ-036 rst asserted mid-RXCRC -> next cycle: IDLE, crc=0, busy=0; no crc_ready pulse follows.
REQ-037 start asserted in RXCRC after 5 CRC bits -> restarts CALC, counter=0, crc re-initialised; the subsequent frame checks correctly.
REQ-038 bit_valid pulses while IDLE -> crc unchanged, busy=0, no crc_ready.
